multicycle_control: RTL and testbench

Multi-cycle main control FSM for the LEGv8 datapath. It sequences each instruction through fetch, decode, execute, memory and write-back states. It drives the datapath enables and the 2-bit `ALUop` consumed by the downstream `ALUControl` stage. It replaces single-cycle combinational control, so instruction and data memory can share one wait-state handshake (`MemReady`).

---
 rtl/legv8_pkg.sv | 56 +++++
 rtl/opcode_class.sv | 29 ++
 rtl/multicycle_control.sv | 148 ++++++++++++++
 tb/tb_multicycle_control.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/legv8_pkg.sv
// Shared LEGv8 encodings: opcode patterns, instruction classes, ALUop codes
// and the multi-cycle control state numbering.
package legv8_pkg;

  typedef enum logic [3:0] {
    ST_FETCH  = 4'd0,
    ST_DECODE = 4'd1,
    ST_EXEC_R = 4'd2,
    ST_WB_R   = 4'd3,
    ST_ADDR   = 4'd4,
    ST_MEM_RD = 4'd5,
    ST_WB_MEM = 4'd6,
    ST_MEM_WR = 4'd7,
    ST_CBZ_BR = 4'd8,
    ST_B_BR   = 4'd9,
    ST_HALT   = 4'd15
  } state_t;

  typedef enum logic [2:0] {
    CLS_R       = 3'd0,
    CLS_ORRI    = 3'd1,
    CLS_LSL     = 3'd2,
    CLS_LDUR    = 3'd3,
    CLS_STUR    = 3'd4,
    CLS_CBZ     = 3'd5,
    CLS_B       = 3'd6,
    CLS_ILLEGAL = 3'd7
  } op_class_t;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_PASSB = 2'b01;
  localparam logic [1:0] ALUOP_RTYPE = 2'b10;

  localparam logic [10:0] OP_ADD  = 11'b10001011000;
  localparam logic [10:0] OP_SUB  = 11'b11001011000;
  localparam logic [10:0] OP_AND  = 11'b10001010000;
  localparam logic [10:0] OP_ORR  = 11'b10101010000;
  localparam logic [10:0] OP_LSL  = 11'b11010011011;
  localparam logic [10:0] OP_LDUR = 11'b11111000010;
  localparam logic [10:0] OP_STUR = 11'b11111000000;

  // Families that carry immediate/offset bits inside the opcode field.
  localparam logic [10:0] OP_ORRI   = 11'b10110010000;
  localparam logic [10:0] MASK_ORRI = 11'b11111111110;
  localparam logic [10:0] OP_CBZ    = 11'b10110100000;
  localparam logic [10:0] MASK_CBZ  = 11'b11111111000;
  localparam logic [10:0] OP_B      = 11'b00010100000;
  localparam logic [10:0] MASK_B    = 11'b11111100000;

  function automatic logic op_match(input logic [10:0] op,
                                    input logic [10:0] pattern,
                                    input logic [10:0] mask);
    return (op & mask) == pattern;
  endfunction

endpackage

// File: rtl/opcode_class.sv
// Combinational decode of the 11-bit LEGv8 opcode field into an instruction
// class; shared by the multi-cycle FSM and the pipeline decoder.
module opcode_class
  import legv8_pkg::*;
(
  input  logic [10:0] opcode,
  output logic [2:0]  op_class
);

  always_comb begin
    op_class = CLS_ILLEGAL;
    if (opcode == OP_ADD || opcode == OP_SUB ||
        opcode == OP_AND || opcode == OP_ORR)
      op_class = CLS_R;
    else if (op_match(opcode, OP_ORRI, MASK_ORRI))
      op_class = CLS_ORRI;
    else if (opcode == OP_LSL)
      op_class = CLS_LSL;
    else if (opcode == OP_LDUR)
      op_class = CLS_LDUR;
    else if (opcode == OP_STUR)
      op_class = CLS_STUR;
    else if (op_match(opcode, OP_CBZ, MASK_CBZ))
      op_class = CLS_CBZ;
    else if (op_match(opcode, OP_B, MASK_B))
      op_class = CLS_B;
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle LEGv8 main control FSM: sequences fetch/decode/execute/memory/
// write-back and drives datapath strobes, with a shared MemReady wait handshake.
module multicycle_control
  import legv8_pkg::*;
(
  input  logic        CLK,
  input  logic        ResetL,
  input  logic [10:0] Opcode,
  input  logic        Zero,
  input  logic        MemReady,
  output logic [1:0]  ALUop,
  output logic        ALUSrc,
  output logic        Reg2Loc,
  output logic        MemtoReg,
  output logic        RegWrite,
  output logic        MemRead,
  output logic        MemWrite,
  output logic        InstrRead,
  output logic        IRWrite,
  output logic        PCWrite,
  output logic        PCSrc,
  output logic        IllegalOp,
  output logic [3:0]  State
);

  state_t     state_q, state_d;
  logic [2:0] cls_bits;
  op_class_t  cls;
  logic       imm_op, is_store;

  logic [1:0] alu_op;
  logic       alu_src, reg2loc, mem_to_reg, reg_write, mem_read, mem_write;
  logic       instr_read, ir_write, pc_write, pc_src, illegal_op;

  opcode_class u_opcode_class (
    .opcode   (Opcode),
    .op_class (cls_bits)
  );

  assign cls      = op_class_t'(cls_bits);
  assign imm_op   = (cls == CLS_ORRI) || (cls == CLS_LSL);
  assign is_store = (cls == CLS_STUR);

  always_ff @(posedge CLK or negedge ResetL) begin
    if (!ResetL) state_q <= ST_FETCH;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d    = state_q;
    alu_op     = ALUOP_ADD;
    alu_src    = 1'b0;
    reg2loc    = 1'b0;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    instr_read = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    illegal_op = 1'b0;
    case (state_q)
      ST_FETCH: begin
        instr_read = 1'b1;
        if (MemReady) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
          state_d  = ST_DECODE;
        end
      end
      ST_DECODE: begin
        case (cls)
          CLS_R, CLS_ORRI, CLS_LSL: state_d = ST_EXEC_R;
          CLS_LDUR, CLS_STUR:       state_d = ST_ADDR;
          CLS_CBZ:                  state_d = ST_CBZ_BR;
          CLS_B:                    state_d = ST_B_BR;
          default:                  state_d = ST_HALT;
        endcase
      end
      ST_EXEC_R: begin
        alu_op  = ALUOP_RTYPE;
        alu_src = imm_op;
        state_d = ST_WB_R;
      end
      ST_WB_R: begin
        alu_op    = ALUOP_RTYPE;
        alu_src   = imm_op;
        reg_write = 1'b1;
        state_d   = ST_FETCH;
      end
      ST_ADDR: begin
        alu_src = 1'b1;
        reg2loc = is_store;
        state_d = is_store ? ST_MEM_WR : ST_MEM_RD;
      end
      ST_MEM_RD: begin
        alu_src  = 1'b1;
        mem_read = 1'b1;
        if (MemReady) state_d = ST_WB_MEM;
      end
      ST_WB_MEM: begin
        reg_write  = 1'b1;
        mem_to_reg = 1'b1;
        state_d    = ST_FETCH;
      end
      ST_MEM_WR: begin
        alu_src   = 1'b1;
        reg2loc   = 1'b1;
        mem_write = 1'b1;
        if (MemReady) state_d = ST_FETCH;
      end
      // Zero feeds PCWrite directly; the PC only samples it at the edge.
      ST_CBZ_BR: begin
        alu_op   = ALUOP_PASSB;
        reg2loc  = 1'b1;
        pc_src   = 1'b1;
        pc_write = Zero;
        state_d  = ST_FETCH;
      end
      ST_B_BR: begin
        pc_src   = 1'b1;
        pc_write = 1'b1;
        state_d  = ST_FETCH;
      end
      ST_HALT: begin
        illegal_op = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase
  end

  // Gating with ResetL kills every strobe the moment reset falls.
  assign ALUop     = ResetL ? alu_op : 2'b00;
  assign ALUSrc    = ResetL & alu_src;
  assign Reg2Loc   = ResetL & reg2loc;
  assign MemtoReg  = ResetL & mem_to_reg;
  assign RegWrite  = ResetL & reg_write;
  assign MemRead   = ResetL & mem_read;
  assign MemWrite  = ResetL & mem_write;
  assign InstrRead = ResetL & instr_read;
  assign IRWrite   = ResetL & ir_write;
  assign PCWrite   = ResetL & pc_write;
  assign PCSrc     = ResetL & pc_src;
  assign IllegalOp = ResetL & illegal_op;
  assign State     = state_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized self-checking bench for multicycle_control: instruction-level
// reference model expands each instruction into its expected per-cycle trace.
module tb_multicycle_control;

  logic        CLK = 1'b0;
  logic        ResetL;
  logic [10:0] Opcode;
  logic        Zero;
  logic        MemReady;
  logic [1:0]  ALUop;
  logic        ALUSrc, Reg2Loc, MemtoReg, RegWrite, MemRead, MemWrite;
  logic        InstrRead, IRWrite, PCWrite, PCSrc, IllegalOp;
  logic [3:0]  State;

  int checks = 0;
  int fails  = 0;

  localparam int K_R = 0, K_ORRI = 1, K_LSL = 2, K_LDUR = 3, K_STUR = 4,
                 K_CBZ = 5, K_B = 6, K_ILL = 7;

  localparam logic [12:0] A_RT   = 13'b1_0000_0000_0000;
  localparam logic [12:0] A_PB   = 13'b0_1000_0000_0000;
  localparam logic [12:0] SRC    = 13'b0_0100_0000_0000;
  localparam logic [12:0] R2L    = 13'b0_0010_0000_0000;
  localparam logic [12:0] M2R    = 13'b0_0001_0000_0000;
  localparam logic [12:0] RW     = 13'b0_0000_1000_0000;
  localparam logic [12:0] MRD    = 13'b0_0000_0100_0000;
  localparam logic [12:0] MWR    = 13'b0_0000_0010_0000;
  localparam logic [12:0] IRD    = 13'b0_0000_0001_0000;
  localparam logic [12:0] IRW    = 13'b0_0000_0000_1000;
  localparam logic [12:0] PCW    = 13'b0_0000_0000_0100;
  localparam logic [12:0] PCS    = 13'b0_0000_0000_0010;
  localparam logic [12:0] ILL    = 13'b0_0000_0000_0001;

  multicycle_control dut (
    .CLK       (CLK),
    .ResetL    (ResetL),
    .Opcode    (Opcode),
    .Zero      (Zero),
    .MemReady  (MemReady),
    .ALUop     (ALUop),
    .ALUSrc    (ALUSrc),
    .Reg2Loc   (Reg2Loc),
    .MemtoReg  (MemtoReg),
    .RegWrite  (RegWrite),
    .MemRead   (MemRead),
    .MemWrite  (MemWrite),
    .InstrRead (InstrRead),
    .IRWrite   (IRWrite),
    .PCWrite   (PCWrite),
    .PCSrc     (PCSrc),
    .IllegalOp (IllegalOp),
    .State     (State)
  );

  always #5 CLK = ~CLK;

  function automatic int classify(input logic [10:0] op);
    if (op ==? 11'b10001011000 || op ==? 11'b11001011000 ||
        op ==? 11'b10001010000 || op ==? 11'b10101010000) return K_R;
    if (op ==? 11'b1011001000?) return K_ORRI;
    if (op ==? 11'b11010011011) return K_LSL;
    if (op ==? 11'b11111000010) return K_LDUR;
    if (op ==? 11'b11111000000) return K_STUR;
    if (op ==? 11'b10110100???) return K_CBZ;
    if (op ==? 11'b000101?????) return K_B;
    return K_ILL;
  endfunction

  function automatic logic [10:0] pickOpcode(input int kind);
    logic [10:0] op;
    logic [10:0] rops [4];
    rops = '{11'b10001011000, 11'b11001011000, 11'b10001010000, 11'b10101010000};
    case (kind)
      K_R:    op = rops[$urandom_range(0, 3)];
      K_ORRI: op = {10'b1011001000, 1'($urandom)};
      K_LSL:  op = 11'b11010011011;
      K_LDUR: op = 11'b11111000010;
      K_STUR: op = 11'b11111000000;
      K_CBZ:  op = {8'b10110100, 3'($urandom)};
      K_B:    op = {6'b000101, 5'($urandom)};
      default: begin
        op = 11'($urandom);
        while (classify(op) != K_ILL) op = 11'($urandom);
      end
    endcase
    return op;
  endfunction

  function automatic logic [16:0] ev(input int st, input logic [12:0] bits);
    return {4'(st), bits};
  endfunction

  task automatic checkOutput(input string tag, input logic [16:0] expected);
    logic [16:0] observed;
    observed = {State, ALUop, ALUSrc, Reg2Loc, MemtoReg, RegWrite, MemRead,
                MemWrite, InstrRead, IRWrite, PCWrite, PCSrc, IllegalOp};
    checks++;
    assert (observed === expected)
    else begin
      fails++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Entered at a falling edge; drives inputs, checks mid-cycle, leaves at the next falling edge.
  task automatic applyStimulus(input logic mr, input logic z, input string tag,
                               input logic [16:0] expected);
    MemReady = mr;
    Zero     = z;
    #2;
    checkOutput(tag, expected);
    @(negedge CLK);
  endtask

  function automatic logic rnd();
    return 1'($urandom);
  endfunction

  task automatic runInstruction(input int kind, input logic [10:0] op,
                                input int fetch_wait, input int mem_wait,
                                input logic z);
    logic [12:0] src;
    Opcode = op;
    repeat (fetch_wait) applyStimulus(1'b0, rnd(), "fetch_wait", ev(0, IRD));
    applyStimulus(1'b1, rnd(), "fetch", ev(0, IRD | IRW | PCW));
    applyStimulus(rnd(), rnd(), "decode", ev(1, 13'd0));
    src = (kind == K_ORRI || kind == K_LSL) ? SRC : 13'd0;
    case (kind)
      K_R, K_ORRI, K_LSL: begin
        applyStimulus(rnd(), rnd(), "exec_r", ev(2, A_RT | src));
        applyStimulus(rnd(), rnd(), "wb_r", ev(3, A_RT | src | RW));
      end
      K_LDUR: begin
        applyStimulus(rnd(), rnd(), "addr_ld", ev(4, SRC));
        repeat (mem_wait) applyStimulus(1'b0, rnd(), "mem_rd_wait", ev(5, SRC | MRD));
        applyStimulus(1'b1, rnd(), "mem_rd", ev(5, SRC | MRD));
        applyStimulus(rnd(), rnd(), "wb_mem", ev(6, RW | M2R));
      end
      K_STUR: begin
        applyStimulus(rnd(), rnd(), "addr_st", ev(4, SRC | R2L));
        repeat (mem_wait) applyStimulus(1'b0, rnd(), "mem_wr_wait", ev(7, SRC | R2L | MWR));
        applyStimulus(1'b1, rnd(), "mem_wr", ev(7, SRC | R2L | MWR));
      end
      K_CBZ: begin
        MemReady = rnd();
        Zero = ~z;
        #1;
        Zero = z;
        #1;
        checkOutput("cbz_br", ev(8, A_PB | R2L | PCS | (z ? PCW : 13'd0)));
        @(negedge CLK);
      end
      K_B: applyStimulus(rnd(), rnd(), "b_br", ev(9, PCS | PCW));
      default: begin
        repeat (20) applyStimulus(rnd(), rnd(), "halt", ev(15, ILL));
      end
    endcase
  endtask

  initial begin
    int kind;
    ResetL   = 1'b0;
    Opcode   = 11'd0;
    Zero     = 1'b0;
    MemReady = 1'b1;
    #2;
    checkOutput("reset_idle", ev(0, 13'd0));
    @(negedge CLK);
    checkOutput("reset_held", ev(0, 13'd0));
    ResetL = 1'b1;

    // Directed cases from the plan, then a randomized instruction stream.
    runInstruction(K_R, 11'b10001011000, 0, 0, 1'b0);
    runInstruction(K_LDUR, 11'b11111000010, 0, 2, 1'b0);
    runInstruction(K_CBZ, 11'b10110100101, 0, 0, 1'b1);
    runInstruction(K_CBZ, 11'b10110100000, 1, 0, 1'b0);
    runInstruction(K_ORRI, 11'b10110010001, 0, 0, 1'b0);
    runInstruction(K_LSL, 11'b11010011011, 0, 0, 1'b0);
    runInstruction(K_STUR, 11'b11111000000, 2, 1, 1'b0);
    runInstruction(K_B, 11'b00010111111, 0, 0, 1'b0);

    for (int i = 0; i < 60; i++) begin
      kind = $urandom_range(0, 6);
      runInstruction(kind, pickOpcode(kind), ($urandom_range(0, 3) == 0) ? $urandom_range(1, 3) : 0,
                     $urandom_range(0, 3), rnd());
    end

    runInstruction(K_ILL, 11'b00000000000, 0, 0, 1'b0);
    ResetL = 1'b0;
    #2;
    checkOutput("halt_reset", ev(0, 13'd0));
    @(negedge CLK);
    ResetL = 1'b1;
    runInstruction(K_B, 11'b00010100001, 0, 0, 1'b0);
    runInstruction(K_ILL, pickOpcode(K_ILL), 1, 0, 1'b0);
    ResetL = 1'b0;
    #2;
    checkOutput("halt_reset2", ev(0, 13'd0));
    @(negedge CLK);
    ResetL = 1'b1;

    // Abort a store while it waits on memory.
    Opcode = 11'b11111000000;
    applyStimulus(1'b1, 1'b0, "ab_fetch", ev(0, IRD | IRW | PCW));
    applyStimulus(1'b0, 1'b0, "ab_decode", ev(1, 13'd0));
    applyStimulus(1'b0, 1'b0, "ab_addr", ev(4, SRC | R2L));
    MemReady = 1'b0;
    #2;
    checkOutput("ab_mem_wr", ev(7, SRC | R2L | MWR));
    #1;
    ResetL = 1'b0;
    #1;
    checkOutput("ab_reset", ev(0, 13'd0));
    @(negedge CLK);
    checkOutput("ab_reset_held", ev(0, 13'd0));
    ResetL = 1'b1;
    runInstruction(K_R, 11'b10101010000, 0, 0, 1'b0);
    runInstruction(K_LDUR, 11'b11111000010, 1, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
